cordic_arbiter: RTL and testbench
=================================

Name: cordic_arbiter

Overview:
Shares one free-running pipelined CORDIC core (vectoring mode, 17-bit signed x/y/theta, fixed issue-to-result latency, no backpressure) among NUM_REQ requesters. Each cycle the block grants at most one request round-robin, drives the core inputs, and carries a tag alongside the pipeline. It steers each result into the issuing requester's one-entry response buffer. Sits between the core and the consumers (magnitude/phase users).

Parameters:
NUM_REQ, 4, number of requesters (2..8)
REQ_BITS, 2, clog2(NUM_REQ), tag width
XY_BITS, 16, x/y magnitude bits; buses are XY_BITS+1 wide, signed
THETA_BITS, 16, angle bits; buses are THETA_BITS+1 wide, signed
LATENCY, 15, cycles from core input to core output; must match core build

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester request strobe
req_ready  out  NUM_REQ  per-requester accept; accept = valid & ready
req_x  in  NUM_REQ*(XY_BITS+1)  flat x operands, requester i at slice i
req_y  in  NUM_REQ*(XY_BITS+1)  flat y operands
req_theta  in  NUM_REQ*(THETA_BITS+1)  flat theta operands
cor_x  out  XY_BITS+1  registered core x input
cor_y  out  XY_BITS+1  registered core y input
cor_theta  out  THETA_BITS+1  registered core theta input
cor_x_o  in  XY_BITS+1  core x result
cor_y_o  in  XY_BITS+1  core y result
cor_theta_o  in  THETA_BITS+1  core theta result
rsp_valid  out  NUM_REQ  result buffer i full
rsp_ready  in  NUM_REQ  consumer i takes result
rsp_x  out  NUM_REQ*(XY_BITS+1)  flat buffered x results
rsp_y  out  NUM_REQ*(XY_BITS+1)  flat buffered y results
rsp_theta  out  NUM_REQ*(THETA_BITS+1)  flat buffered theta results

Behaviour:
- Credit: one credit per requester. busy[i] is set on accept and cleared on rsp_valid[i] & rsp_ready[i]. A requester is eligible iff req_valid[i] and !busy[i].
- Arbitration: combinational round-robin over eligible requesters, searching from ptr+1 upward with wrap. req_ready is one-hot or zero, and req_ready[i] is never asserted while busy[i]. ptr updates to the granted index only on a grant. Reset ptr = NUM_REQ-1, so requester 0 wins first.
- Issue: on the accept edge, cor_x/y/theta load the granted operands, and tag stage 0 loads {1, idx}. With no grant, cor_* load 0 and the stage-0 valid loads 0.
- Tag pipe: LATENCY+1 stages of {vld, tag}, shifting every cycle. The last stage is aligned with cor_*_o.
- Capture: when the last tag stage has vld set, cor_x_o/cor_y_o/cor_theta_o are written to buffer[tag] and rsp_valid[tag] sets on the next edge. Overflow is impossible by credit.
- Latency: rsp_valid[i] rises exactly LATENCY+1 cycles after the accept edge. Throughput is 1 issue/cycle aggregate and 1 outstanding per requester.
- Release: on rsp handshake, rsp_valid[i] and busy[i] clear on that edge. The same requester can be granted no earlier than the following cycle, because eligibility uses registered busy.
- A capture for requester j and a handshake for requester k≠j in the same cycle are both performed.
- rsp_x/y/theta hold their value while rsp_valid is low; the value is don't-care to consumers.
- Reset (any time, including mid-operation): busy, rsp_valid, tag pipe valids, cor_*, and buffers = 0; ptr = NUM_REQ-1. In-flight core data after reset is discarded because its tags are invalid.
- Arithmetic: pure steering, no width changes. Values are passed bit-exact.

Optional Feature:
CORDIC_ARB_STATS_EN
- Defined: adds outputs stat_issued[15:0], stat_stall[15:0] and input stat_clr.
  - stat_issued counts accepts.
  - stat_stall counts cycles where any req_valid[i] & busy[i].
  - Both saturate at 16'hFFFF, clear synchronously on stat_clr, and clear asynchronously on rst.
- Undefined: ports and logic absent. The rest of the behaviour is identical.

Test Plan:
- Single request: after reset, req0 x=256, y=256, theta=0 pulsed one cycle → req_ready[0]=1 that cycle; rsp_valid[0] rises 16 cycles later; rsp_theta ≈ 11520 (45° U8.8) ±4; rsp_x ≈ 596 ±4; rsp_y ≈ 0 ±4; other rsp_valid stay 0.
- Round-robin: all 4 req_valid held high with distinct operands → grants 0,1,2,3 on consecutive cycles; results land in buffers 0..3 on cycles 16..19 after the first grant; each buffer matches its own operands per the core model.
- Credit block: req0 holds valid and never asserts rsp_ready → exactly one accept; req_ready[0] stays 0. Asserting rsp_ready[0] for one cycle → req0 is re-granted on the next cycle, not the same one.
- Simultaneous: capture into buffer 2 on the same edge as a handshake on buffer 1 → rsp_valid[2]=1, rsp_valid[1]=0, and busy[1] is cleared.
- Mid-flight reset: rst asserted 5 cycles after 3 accepts → all rsp_valid stay 0 for the next 20 cycles; the next grant goes to requester 0.
- With CORDIC_ARB_STATS_EN: 10 accepts plus 7 blocked cycles → stat_issued=10, stat_stall=7. Forcing stat_issued to 16'hFFFF, further accepts leave it at 16'hFFFF; stat_clr → both counters 0.

Source files
------------

// File: rtl/cordic_arbiter.sv
// cordic_arbiter
//   Shares one free-running pipelined CORDIC core (vectoring mode, no
//   backpressure, fixed LATENCY) among NUM_REQ requesters. One request is
//   granted per cycle, round-robin, and only while that requester has no
//   result outstanding. A {valid, tag} pipe runs alongside the core so each
//   result is steered into the issuing requester's one-entry buffer.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   req_valid / req_ready    per-requester request handshake (ready is one-hot or zero)
//   req_x / req_y / req_theta  flat operands, requester i at slice i
//   cor_x / cor_y / cor_theta  registered core inputs
//   cor_x_o / cor_y_o / cor_theta_o  core results, LATENCY cycles after input
//   rsp_valid / rsp_ready    per-requester result handshake
//   rsp_x / rsp_y / rsp_theta  flat buffered results
//
// Optional build macro CORDIC_ARB_STATS_EN adds stat_clr (in) and the
// saturating counters stat_issued / stat_stall (out).

module cordic_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned REQ_BITS   = 2,
  parameter int unsigned XY_BITS    = 16,
  parameter int unsigned THETA_BITS = 16,
  parameter int unsigned LATENCY    = 15
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*(XY_BITS+1)-1:0]      req_x,
  input  logic [NUM_REQ*(XY_BITS+1)-1:0]      req_y,
  input  logic [NUM_REQ*(THETA_BITS+1)-1:0]   req_theta,
  output logic signed [XY_BITS:0]             cor_x,
  output logic signed [XY_BITS:0]             cor_y,
  output logic signed [THETA_BITS:0]          cor_theta,
  input  logic signed [XY_BITS:0]             cor_x_o,
  input  logic signed [XY_BITS:0]             cor_y_o,
  input  logic signed [THETA_BITS:0]          cor_theta_o,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  input  logic [NUM_REQ-1:0]                  rsp_ready,
  output logic [NUM_REQ*(XY_BITS+1)-1:0]      rsp_x,
  output logic [NUM_REQ*(XY_BITS+1)-1:0]      rsp_y,
  output logic [NUM_REQ*(THETA_BITS+1)-1:0]   rsp_theta
`ifdef CORDIC_ARB_STATS_EN
  ,
  input  logic                                stat_clr,
  output logic [15:0]                         stat_issued,
  output logic [15:0]                         stat_stall
`endif
);

  localparam int unsigned XW = XY_BITS + 1;
  localparam int unsigned TW = THETA_BITS + 1;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [NUM_REQ-1:0]               busy_q, busy_d;
  logic [NUM_REQ-1:0]               rsp_valid_q, rsp_valid_d;
  logic [REQ_BITS-1:0]              ptr_q, ptr_d;
  logic [XW-1:0]                    cor_x_q, cor_x_d;
  logic [XW-1:0]                    cor_y_q, cor_y_d;
  logic [TW-1:0]                    cor_theta_q, cor_theta_d;
  logic [LATENCY:0]                 tag_vld_q, tag_vld_d;
  logic [LATENCY:0][REQ_BITS-1:0]   tag_idx_q, tag_idx_d;
  logic [NUM_REQ*XW-1:0]            rsp_x_q, rsp_x_d;
  logic [NUM_REQ*XW-1:0]            rsp_y_q, rsp_y_d;
  logic [NUM_REQ*TW-1:0]            rsp_theta_q, rsp_theta_d;

  // ---------------------------------------------------------------------
  // Round-robin arbitration over requesters that hold no credit
  // ---------------------------------------------------------------------
  logic [NUM_REQ-1:0]  elig;
  logic                gnt_vld;
  logic [REQ_BITS-1:0] gnt_idx;
  logic [NUM_REQ-1:0]  gnt_oh;

  assign elig = req_valid & ~busy_q;

  always_comb begin
    int unsigned cand;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    cand    = 0;
    // Search ptr+1, ptr+2, ... with wrap; ptr < NUM_REQ so one subtract wraps.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = 32'(ptr_q) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!gnt_vld && cand == j && elig[j]) begin
          gnt_vld = 1'b1;
          gnt_idx = REQ_BITS'(j);
        end
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      gnt_oh[i] = gnt_vld && (gnt_idx == REQ_BITS'(i));
    end
  end

  // ---------------------------------------------------------------------
  // Issue, tag pipe, capture and release
  // ---------------------------------------------------------------------
  logic [NUM_REQ-1:0]  hs;
  logic                cap_vld;
  logic [REQ_BITS-1:0] cap_idx;
  logic [NUM_REQ-1:0]  cap_oh;

  assign hs      = rsp_valid_q & rsp_ready;
  assign cap_vld = tag_vld_q[LATENCY];
  assign cap_idx = tag_idx_q[LATENCY];

  always_comb begin
    ptr_d       = gnt_vld ? gnt_idx : ptr_q;
    cor_x_d     = '0;
    cor_y_d     = '0;
    cor_theta_d = '0;
    cap_oh      = '0;
    rsp_x_d     = rsp_x_q;
    rsp_y_d     = rsp_y_q;
    rsp_theta_d = rsp_theta_q;

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        cor_x_d     = req_x[i*XW +: XW];
        cor_y_d     = req_y[i*XW +: XW];
        cor_theta_d = req_theta[i*TW +: TW];
      end
      if (cap_vld && cap_idx == REQ_BITS'(i)) begin
        cap_oh[i]               = 1'b1;
        rsp_x_d[i*XW +: XW]     = cor_x_o;
        rsp_y_d[i*XW +: XW]     = cor_y_o;
        rsp_theta_d[i*TW +: TW] = cor_theta_o;
      end
    end

    tag_vld_d = {tag_vld_q[LATENCY-1:0], gnt_vld};
    tag_idx_d = {tag_idx_q[LATENCY-1:0], gnt_idx};

    // A capture can never target a requester in handshake (its buffer is
    // empty while in flight), so set and clear terms are independent.
    rsp_valid_d = (rsp_valid_q & ~hs) | cap_oh;
    busy_d      = (busy_q & ~hs) | gnt_oh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      rsp_valid_q <= '0;
      ptr_q       <= REQ_BITS'(NUM_REQ - 1);
      cor_x_q     <= '0;
      cor_y_q     <= '0;
      cor_theta_q <= '0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
      rsp_x_q     <= '0;
      rsp_y_q     <= '0;
      rsp_theta_q <= '0;
    end else begin
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      ptr_q       <= ptr_d;
      cor_x_q     <= cor_x_d;
      cor_y_q     <= cor_y_d;
      cor_theta_q <= cor_theta_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
      rsp_x_q     <= rsp_x_d;
      rsp_y_q     <= rsp_y_d;
      rsp_theta_q <= rsp_theta_d;
    end
  end

  assign req_ready = gnt_oh;
  assign cor_x     = cor_x_q;
  assign cor_y     = cor_y_q;
  assign cor_theta = cor_theta_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_x     = rsp_x_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_theta = rsp_theta_q;

  // ---------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------
`ifdef CORDIC_ARB_STATS_EN
  logic [15:0] stat_issued_q, stat_issued_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_stall_d  = stat_stall_q;
    if (stat_clr) begin
      stat_issued_d = '0;
      stat_stall_d  = '0;
    end else begin
      if (gnt_vld && stat_issued_q != '1) stat_issued_d = stat_issued_q + 16'd1;
      if (|(req_valid & busy_q) && stat_stall_q != '1) stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter
//   Directed plus randomized bench for cordic_arbiter. A behavioural
//   vectoring core (real arithmetic, LATENCY-deep delay) feeds the DUT; a
//   transaction-level model (credits, pointer, pending-result queue) predicts
//   grants, response timing and buffer contents.

`timescale 1ns/1ps

module tb_cordic_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned RB  = 2;
  localparam int unsigned LAT = 15;
  localparam int unsigned XW  = 17;
  localparam int unsigned TW  = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*XW-1:0]   req_x = '0;
  logic [N*XW-1:0]   req_y = '0;
  logic [N*TW-1:0]   req_theta = '0;
  logic [XW-1:0]     cor_x, cor_y;
  logic [TW-1:0]     cor_theta;
  logic [XW-1:0]     cor_x_o, cor_y_o;
  logic [TW-1:0]     cor_theta_o;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready = '0;
  logic [N*XW-1:0]   rsp_x, rsp_y;
  logic [N*TW-1:0]   rsp_theta;
`ifdef CORDIC_ARB_STATS_EN
  logic              stat_clr = 1'b0;
  logic [15:0]       stat_issued, stat_stall;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  cordic_arbiter #(
    .NUM_REQ(N), .REQ_BITS(RB), .XY_BITS(16), .THETA_BITS(16), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_theta(req_theta),
    .cor_x(cor_x), .cor_y(cor_y), .cor_theta(cor_theta),
    .cor_x_o(cor_x_o), .cor_y_o(cor_y_o), .cor_theta_o(cor_theta_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_theta(rsp_theta)
`ifdef CORDIC_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  // ---------------- behavioural vectoring core ----------------
  // Magnitude scaled by the CORDIC gain, angle in U8.8 degrees added to
  // theta, and a small deterministic y residual so the y path carries data.
  function automatic logic [XW-1:0] f_x(input logic [XW-1:0] x, input logic [XW-1:0] y);
    int xi, yi;
    real rx, ry;
    xi = int'($signed(x)); yi = int'($signed(y));
    rx = xi; ry = yi;
    return XW'($rtoi($sqrt(rx*rx + ry*ry) * 1.646760258 + 0.5));
  endfunction

  function automatic logic [XW-1:0] f_y(input logic [XW-1:0] x, input logic [XW-1:0] y);
    int s;
    s = int'($signed(x)) + int'($signed(y));
    return XW'((s % 5) - 2);
  endfunction

  function automatic logic [TW-1:0] f_t(input logic [XW-1:0] x, input logic [XW-1:0] y,
                                        input logic [TW-1:0] t);
    int xi, yi, ti, a;
    real rx, ry;
    xi = int'($signed(x)); yi = int'($signed(y)); ti = int'($signed(t));
    rx = xi; ry = yi;
    a = $rtoi($atan2(ry, rx) * 180.0 / 3.141592653589793 * 256.0 + 0.5);
    return TW'(ti + a);
  endfunction

  logic [XW-1:0] px [LAT];
  logic [XW-1:0] py [LAT];
  logic [TW-1:0] pt [LAT];

  always @(posedge clk) begin
    px[0] <= f_x(cor_x, cor_y);
    py[0] <= f_y(cor_x, cor_y);
    pt[0] <= f_t(cor_x, cor_y, cor_theta);
    for (int k = LAT - 1; k > 0; k--) begin
      px[k] <= px[k-1];
      py[k] <= py[k-1];
      pt[k] <= pt[k-1];
    end
  end

  assign cor_x_o     = px[LAT-1];
  assign cor_y_o     = py[LAT-1];
  assign cor_theta_o = pt[LAT-1];

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int target, input int tol);
    checks++;
    assert (obs >= target - tol && obs <= target + tol) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d+-%0d", tag, obs, target, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input int x, input int y, input int t);
    req_x[i*XW +: XW]     = XW'(x);
    req_y[i*XW +: XW]     = XW'(y);
    req_theta[i*TW +: TW] = TW'(t);
  endtask

  // ---------------- reference model state ----------------
  typedef struct {
    int            idx;
    int            due;
    logic [XW-1:0] x;
    logic [XW-1:0] y;
    logic [TW-1:0] t;
  } pend_t;

  pend_t         pend [$];
  bit            m_busy [N];
  bit            m_rsp  [N];
  logic [XW-1:0] m_bx   [N];
  logic [XW-1:0] m_by   [N];
  logic [TW-1:0] m_bt   [N];
  int            m_ptr;

  initial begin
    int k, acc, eg, c0;
    int arrive [N];
    bit quiet;
    logic [N-1:0] exp_ready, exp_rsp;
    logic [XW-1:0] ox, oy;
    logic [TW-1:0] ot;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_cor_x", 64'(cor_x), 64'(0));
    check("rst_rsp_x", 64'(rsp_x), 64'(0));
    rst = 1'b0;

    // ---- single request ----
    tick();
    set_req(0, 256, 256, 0);
    req_valid = 4'b0001;
    #1;
    check("single_ready", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0;
    k = 0;
    while (!rsp_valid[0] && k < 40) begin tick(); k++; end
    check("single_latency", 64'(k), 64'(LAT + 1));
    check_near("single_x", int'($signed(rsp_x[0 +: XW])), 596, 4);
    check_near("single_y", int'($signed(rsp_y[0 +: XW])), 0, 4);
    check_near("single_theta", int'($signed(rsp_theta[0 +: TW])), 11520, 4);
    check("single_others", 64'(rsp_valid[3:1]), 64'(0));
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    check("single_release", 64'(rsp_valid), 64'(0));

    // ---- round robin ----
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 100 * (i + 1), 60 * i + 30, 5 * i);
    req_valid = '1;
    c0 = 0;
    for (int j = 0; j < N; j++) begin
      #1;
      check($sformatf("rr_grant%0d", j), 64'(req_ready), 64'(1 << j));
      tick();
      if (j == 0) c0 = cyc;
    end
    req_valid = '0;
    for (int i = 0; i < N; i++) arrive[i] = -1;
    k = 0;
    while (rsp_valid != 4'b1111 && k < 40) begin
      tick(); k++;
      for (int i = 0; i < N; i++) if (rsp_valid[i] && arrive[i] < 0) arrive[i] = cyc - c0;
    end
    for (int i = 0; i < N; i++) begin
      ox = XW'(100 * (i + 1)); oy = XW'(60 * i + 30); ot = TW'(5 * i);
      check($sformatf("rr_arrive%0d", i), 64'(arrive[i]), 64'(LAT + 1 + i));
      check($sformatf("rr_x%0d", i), 64'(rsp_x[i*XW +: XW]), 64'(f_x(ox, oy)));
      check($sformatf("rr_y%0d", i), 64'(rsp_y[i*XW +: XW]), 64'(f_y(ox, oy)));
      check($sformatf("rr_t%0d", i), 64'(rsp_theta[i*TW +: TW]), 64'(f_t(ox, oy, ot)));
    end

    // ---- credit block ----
    do_reset();
    set_req(0, 300, 100, 7);
    req_valid = 4'b0001;
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (req_ready[0]) acc++;
      tick();
    end
    check("credit_accepts", 64'(acc), 64'(1));
    check("credit_full", 64'(rsp_valid), 64'(4'b0001));
    rsp_ready = 4'b0001;
    #1;
    check("credit_same_cycle", 64'(req_ready[0]), 64'(0));
    tick();
    rsp_ready = '0;
    #1;
    check("credit_next_cycle", 64'(req_ready[0]), 64'(1));
    req_valid = '0;

    // ---- simultaneous capture and handshake ----
    do_reset();
    set_req(1, 500, 20, 0);
    set_req(2, 40, 700, 3);
    req_valid = 4'b0010;
    #1;
    check("sim_grant1", 64'(req_ready), 64'(4'b0010));
    tick();
    req_valid = 4'b0100;
    #1;
    check("sim_grant2", 64'(req_ready), 64'(4'b0100));
    tick();
    req_valid = '0;
    repeat (LAT) tick();
    check("sim_before", 64'(rsp_valid), 64'(4'b0010));
    rsp_ready = 4'b0010;
    tick();
    rsp_ready = '0;
    check("sim_after", 64'(rsp_valid), 64'(4'b0100));
    check("sim_x2", 64'(rsp_x[2*XW +: XW]), 64'(f_x(XW'(40), XW'(700))));
    req_valid = 4'b0010;
    #1;
    check("sim_busy1_clear", 64'(req_ready), 64'(4'b0010));

    // ---- mid-flight reset ----
    do_reset();
    set_req(0, 10, 10, 0); set_req(1, 20, 5, 0); set_req(2, 30, 1, 0);
    req_valid = 4'b0111;
    repeat (3) tick();
    req_valid = '0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("midrst_cor_x", 64'(cor_x), 64'(0));
    tick();
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid !== '0) quiet = 1'b0;
    end
    check("midrst_quiet", 64'(quiet), 64'(1));
    req_valid = '1;
    #1;
    check("midrst_first_grant", 64'(req_ready), 64'(4'b0001));
    req_valid = '0;

`ifdef CORDIC_ARB_STATS_EN
    // ---- statistics: one accept then seven blocked cycles ----
    do_reset();
    set_req(3, 50, 50, 0);
    req_valid = 4'b1000;
    repeat (8) tick();
    req_valid = '0;
    check("stat_issued", 64'(stat_issued), 64'(1));
    check("stat_stall", 64'(stat_stall), 64'(7));
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("stat_clr_issued", 64'(stat_issued), 64'(0));
    check("stat_clr_stall", 64'(stat_stall), 64'(0));
`endif

    // ---- randomized traffic against the transaction model ----
    do_reset();
    for (int i = 0; i < N; i++) begin m_busy[i] = 0; m_rsp[i] = 0; end
    m_ptr = N - 1;
    pend.delete();
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++)
        set_req(i, int'($urandom_range(1, 2000)), int'($urandom_range(0, 2000)),
                int'($urandom_range(0, 1000)));
      req_valid = N'($urandom);
      rsp_ready = N'($urandom) & N'($urandom);
      #1;
      eg = -1;
      for (int off = 1; off <= N; off++) begin
        int c;
        c = (m_ptr + off) % N;
        if (eg < 0 && req_valid[c] && !m_busy[c]) eg = c;
      end
      exp_ready = (eg < 0) ? '0 : N'(1 << eg);
      exp_rsp = '0;
      for (int i = 0; i < N; i++) exp_rsp[i] = m_rsp[i];
      check("rnd_ready", 64'(req_ready), 64'(exp_ready));
      check("rnd_rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
      for (int i = 0; i < N; i++) begin
        if (m_rsp[i]) begin
          check("rnd_x", 64'(rsp_x[i*XW +: XW]), 64'(m_bx[i]));
          check("rnd_y", 64'(rsp_y[i*XW +: XW]), 64'(m_by[i]));
          check("rnd_t", 64'(rsp_theta[i*TW +: TW]), 64'(m_bt[i]));
        end
      end
      for (int i = 0; i < N; i++)
        if (m_rsp[i] && rsp_ready[i]) begin m_rsp[i] = 0; m_busy[i] = 0; end
      if (eg >= 0) begin
        pend_t p;
        p.idx = eg;
        p.due = cyc + 1 + LAT + 1;
        ox = req_x[eg*XW +: XW]; oy = req_y[eg*XW +: XW]; ot = req_theta[eg*TW +: TW];
        p.x = f_x(ox, oy); p.y = f_y(ox, oy); p.t = f_t(ox, oy, ot);
        pend.push_back(p);
        m_busy[eg] = 1;
        m_ptr = eg;
      end
      for (int q = pend.size() - 1; q >= 0; q--) begin
        if (pend[q].due == cyc + 1) begin
          m_rsp[pend[q].idx] = 1;
          m_bx[pend[q].idx]  = pend[q].x;
          m_by[pend[q].idx]  = pend[q].y;
          m_bt[pend[q].idx]  = pend[q].t;
          pend.delete(q);
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
